uart_boot_loader: RTL and testbench

Bus master that sits directly upstream of uart_ctrl and drives its 5-bit handshake register interface. On start it programs the UART divider, flushes both FIFOs, then receives a framed binary image byte by byte over the UART. It writes the image as 32-bit words into instruction/data memory, verifies an XOR checksum, and answers the host with ACK (0x06) or NAK (0x15). It is used to boot the SoC core from a host PC.

---
 rtl/uart_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : uart_boot_loader
// Brief   : Programs uart_ctrl, receives a framed image over the UART, writes
//           it to memory as 32-bit words and answers the host with ACK/NAK.
// Revision: 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter logic [15:0] CLK_DIV   = 16'd868,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] MAX_WORDS = 16'd4096,
    parameter int unsigned MEM_AW    = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o,
    output logic              hs_read_o,
    output logic              hs_write_o,
    output logic [4:0]        hs_addr_o,
    output logic [7:0]        hs_data_o,
    input  logic              hs_ready_i,
    input  logic [7:0]        hs_data_i,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i
);

    localparam logic [4:0] c_addr_rx   = 5'h00;
    localparam logic [4:0] c_addr_tx   = 5'h04;
    localparam logic [4:0] c_addr_stat = 5'h08;
    localparam logic [4:0] c_addr_ctrl = 5'h0C;
    localparam logic [4:0] c_addr_dlo  = 5'h10;
    localparam logic [4:0] c_addr_dhi  = 5'h14;
    localparam logic [7:0] c_magic     = 8'hA5;
    localparam logic [7:0] c_ack       = 8'h06;
    localparam logic [7:0] c_nak       = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG_LO    = 4'd1,
        S_CFG_HI    = 4'd2,
        S_CFG_RST   = 4'd3,
        S_POLL      = 4'd4,
        S_POP       = 4'd5,
        S_GUARD     = 4'd6,
        S_MEM_WR    = 4'd7,
        S_RESP_POLL = 4'd8,
        S_RESP_TX   = 4'd9,
        S_DONE      = 4'd10,
        S_ERR       = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        P_MAGIC = 3'd0,
        P_LEN0  = 3'd1,
        P_LEN1  = 3'd2,
        P_DATA  = 3'd3,
        P_CSUM  = 3'd4
    } phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  resp_q, resp_d;
    logic        guard_q, guard_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [15:0]       w_len;
    logic [15:0]       w_idx_next;
    logic [MEM_AW-1:0] w_mem_addr;

    assign w_len      = {rx_byte_q, len_q[7:0]};
    assign w_idx_next = word_idx_q + 16'd1;
    assign w_mem_addr = MEM_AW'(BASE_ADDR) + (MEM_AW'(word_idx_q) << 2);

    assign busy_o     = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rx_byte_d   = rx_byte_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        resp_d      = resp_q;
        guard_d     = guard_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        hs_read_o   = 1'b0;
        hs_write_o  = 1'b0;
        hs_addr_o   = 5'h00;
        hs_data_o   = 8'h00;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_CFG_LO;
                    phase_d    = P_MAGIC;
                    len_d      = 16'h0;
                    word_idx_d = 16'h0;
                    byte_cnt_d = 2'd0;
                    word_d     = 32'h0;
                    csum_d     = 8'h00;
                    resp_d     = 8'h00;
                    guard_d    = 1'b0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                end
            end
            S_CFG_LO: begin
                hs_write_o = 1'b1;
                hs_addr_o  = c_addr_dlo;
                hs_data_o  = CLK_DIV[7:0];
                if (hs_ready_i) state_d = S_CFG_HI;
            end
            S_CFG_HI: begin
                hs_write_o = 1'b1;
                hs_addr_o  = c_addr_dhi;
                hs_data_o  = CLK_DIV[15:8];
                if (hs_ready_i) state_d = S_CFG_RST;
            end
            S_CFG_RST: begin
                hs_write_o = 1'b1;
                hs_addr_o  = c_addr_ctrl;
                hs_data_o  = 8'h03;
                if (hs_ready_i) state_d = S_POLL;
            end
            S_POLL: begin
                hs_read_o = 1'b1;
                hs_addr_o = c_addr_stat;
                if (hs_ready_i) begin
                    if (hs_data_i[5] || hs_data_i[6]) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end else if (hs_data_i[0]) begin
                        state_d = S_POP;
                    end
                end
            end
            S_POP: begin
                hs_read_o = 1'b1;
                hs_addr_o = c_addr_rx;
                if (hs_ready_i) begin
                    rx_byte_d = hs_data_i;
                    guard_d   = 1'b0;
                    state_d   = S_GUARD;
                end
            end
            S_GUARD: begin
                // Second idle cycle performs the dispatch of the popped byte.
                if (!guard_q) begin
                    guard_d = 1'b1;
                end else begin
                    state_d = S_POLL;
                    case (phase_q)
                        P_MAGIC: if (rx_byte_q == c_magic) phase_d = P_LEN0;
                        P_LEN0: begin
                            len_d   = {8'h00, rx_byte_q};
                            phase_d = P_LEN1;
                        end
                        P_LEN1: begin
                            len_d = w_len;
                            if (w_len > MAX_WORDS) begin
                                state_d    = S_ERR;
                                error_d    = 1'b1;
                                err_code_d = 2'd2;
                            end else if (w_len == 16'h0) begin
                                phase_d = P_CSUM;
                            end else begin
                                phase_d = P_DATA;
                            end
                        end
                        P_DATA: begin
                            case (byte_cnt_q)
                                2'd0:    word_d[7:0]   = rx_byte_q;
                                2'd1:    word_d[15:8]  = rx_byte_q;
                                2'd2:    word_d[23:16] = rx_byte_q;
                                default: word_d[31:24] = rx_byte_q;
                            endcase
                            csum_d     = csum_q ^ rx_byte_q;
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) state_d = S_MEM_WR;
                        end
                        P_CSUM: begin
                            resp_d  = (rx_byte_q == csum_q) ? c_ack : c_nak;
                            state_d = S_RESP_POLL;
                        end
                        default: phase_d = P_MAGIC;
                    endcase
                end
            end
            S_MEM_WR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = w_mem_addr;
                mem_wdata_o = word_q;
                if (mem_ready_i) begin
                    word_idx_d = w_idx_next;
                    state_d    = S_POLL;
                    if (w_idx_next == len_q) phase_d = P_CSUM;
                end
            end
            S_RESP_POLL: begin
                hs_read_o = 1'b1;
                hs_addr_o = c_addr_stat;
                if (hs_ready_i) begin
                    if (hs_data_i[5] || hs_data_i[6]) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end else if (!hs_data_i[3]) begin
                        state_d = S_RESP_TX;
                    end
                end
            end
            S_RESP_TX: begin
                hs_write_o = 1'b1;
                hs_addr_o  = c_addr_tx;
                hs_data_o  = resp_q;
                if (hs_ready_i) begin
                    if (resp_q == c_ack) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            phase_q    <= P_MAGIC;
            rx_byte_q  <= 8'h00;
            len_q      <= 16'h0;
            word_idx_q <= 16'h0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0;
            csum_q     <= 8'h00;
            resp_q     <= 8'h00;
            guard_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rx_byte_q  <= rx_byte_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            resp_q     <= resp_d;
            guard_q    <= guard_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_boot_loader
// Brief   : Scoreboard bench for uart_boot_loader with a small uart_ctrl model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam logic [31:0] B = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, error_o;
    logic [1:0]  err_code_o;
    logic        hs_read_o, hs_write_o;
    logic [4:0]  hs_addr_o;
    logic [7:0]  hs_data_o;
    logic        hs_ready_i = 1'b1;
    logic [7:0]  hs_data_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b1;

    typedef struct {
        bit          is_mem;
        logic [31:0] addr;
        logic [31:0] data;
    } evt_t;
    typedef logic [7:0] bytes_t[$];

    evt_t        exp_q[$];
    logic [7:0]  rx_mem [0:255];
    int          rd_ptr = 0, wr_ptr = 0, force_at = -1;
    logic        tx_full = 1'b0;
    bit          throttle = 1'b0, pop_req = 1'b0;
    int          n_vec = 0, n_err = 0, cyc = 0, cyc_lo = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;
    logic [7:0]  status;
    logic [7:0]  rx_idx;

    uart_boot_loader #(
        .CLK_DIV  (16'd868),
        .BASE_ADDR(B),
        .MAX_WORDS(16'd4096),
        .MEM_AW   (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .err_code_o (err_code_o),
        .hs_read_o  (hs_read_o),
        .hs_write_o (hs_write_o),
        .hs_addr_o  (hs_addr_o),
        .hs_data_o  (hs_data_o),
        .hs_ready_i (hs_ready_i),
        .hs_data_i  (hs_data_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    // uart_ctrl model: status {frame, overrun, -, tx_full, -, -, rx_nempty}
    always_comb begin
        rx_idx = rd_ptr[7:0];
        status = 8'h00;
        status[0] = (rd_ptr != wr_ptr);
        status[3] = tx_full;
        if (force_at >= 0 && rd_ptr == force_at) status = 8'h41;
        hs_data_i = (hs_addr_o == 5'h00) ? rx_mem[rx_idx] : status;
    end

    always @(posedge clk) begin
        #1;
        if (pop_req) begin
            rd_ptr  = rd_ptr + 1;
            pop_req = 1'b0;
        end
        hs_ready_i = throttle ? ~hs_ready_i : 1'b1;
    end

    task automatic check_evt(input bit is_mem, input logic [31:0] a, input logic [31:0] d);
        evt_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s addr=%h data=%h, none required",
                     is_mem ? "mem" : "hs", a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.is_mem != is_mem || e.addr != a || e.data != d) begin
                n_err++;
                $display("FAIL %s_write got mem=%0d addr=%h data=%h, required mem=%0d addr=%h data=%h",
                         is_mem ? "mem" : "hs", is_mem, a, d, e.is_mem, e.addr, e.data);
            end
        end
    endtask

    // Monitor: checks completing transfers and stall behaviour at the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (hs_write_o && hs_ready_i) begin
                check_evt(1'b0, {27'h0, hs_addr_o}, {24'h0, hs_data_o});
                if (hs_addr_o == 5'h10) cyc_lo = cyc;
                if (hs_addr_o == 5'h0C && !throttle) begin
                    n_vec++;
                    if (cyc - cyc_lo != 2) begin
                        n_err++;
                        $display("FAIL cfg_spacing got %0d cycles, required 2", cyc - cyc_lo);
                    end
                end
            end
            if (mem_we_o && mem_ready_i) check_evt(1'b1, mem_addr_o, mem_wdata_o);
            if (mem_we_o) begin
                n_vec++;
                if (hs_read_o || hs_write_o) begin
                    n_err++;
                    $display("FAIL hs_during_mem got rd=%0b wr=%0b, required 0 0", hs_read_o, hs_write_o);
                end
                if (hold_prev && (mem_addr_o != prev_addr || mem_wdata_o != prev_data)) begin
                    n_err++;
                    $display("FAIL mem_hold got %h/%h, required %h/%h",
                             mem_addr_o, mem_wdata_o, prev_addr, prev_data);
                end
            end
            hold_prev = mem_we_o && !mem_ready_i;
            prev_addr = mem_addr_o;
            prev_data = mem_wdata_o;
            if (hs_read_o && hs_ready_i && hs_addr_o == 5'h00) pop_req = 1'b1;
        end
    end

    task automatic exp_hs(input logic [4:0] a, input logic [7:0] d);
        evt_t e;
        e.is_mem = 1'b0; e.addr = {27'h0, a}; e.data = {24'h0, d};
        exp_q.push_back(e);
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic [31:0] d);
        evt_t e;
        e.is_mem = 1'b1; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_cfg();
        exp_hs(5'h10, 8'h64);
        exp_hs(5'h14, 8'h03);
        exp_hs(5'h0C, 8'h03);
    endtask

    task automatic start_dut();
        @(posedge clk); #1;
        rd_ptr = 0; wr_ptr = 0; pop_req = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start got %b, required 1", busy_o);
        end
    endtask

    task automatic put_bytes(input bytes_t b);
        repeat (4) @(posedge clk);
        #1;
        foreach (b[i]) begin
            rx_mem[wr_ptr[7:0]] = b[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy_o && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (busy_o) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout got busy=1 after %0d cycles, required 0", budget);
        end
    endtask

    task automatic check_end(input string name, input logic d, input logic e, input logic [1:0] c);
        @(negedge clk);
        n_vec++;
        if ({done_o, error_o, err_code_o} !== {d, e, c}) begin
            n_err++;
            $display("FAIL %s_flags got done=%b err=%b code=%0d, required done=%b err=%b code=%0d",
                     name, done_o, error_o, err_code_o, d, e, c);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending got %0d outstanding events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({busy_o, done_o, error_o, err_code_o, hs_read_o, hs_write_o, hs_addr_o, hs_data_o,
             mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            n_err++;
            $display("FAIL %s_outputs got busy=%b done=%b err=%b hs_rd=%b hs_wr=%b we=%b addr=%h, required all 0",
                     name, busy_o, done_o, error_o, hs_read_o, hs_write_o, mem_we_o, mem_addr_o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        // Data XOR 11^22^33^44^AA^BB^CC^DD = 0x44
        bytes_t s_ack, s_nak, s_gar, s_err, s_len;
        s_ack = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        s_nak = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        s_gar = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        s_err = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        s_len = '{8'hA5, 8'h01, 8'h10};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Good image -> ACK
        exp_cfg();
        exp_mem(B, 32'h4433_2211);
        exp_mem(B + 32'd4, 32'hDDCC_BBAA);
        exp_hs(5'h04, 8'h06);
        start_dut();
        put_bytes(s_ack);
        wait_idle(2000);
        check_end("ack", 1'b1, 1'b0, 2'd0);

        // Bad checksum -> NAK; a start pulse while busy is ignored
        exp_cfg();
        exp_mem(B, 32'h4433_2211);
        exp_mem(B + 32'd4, 32'hDDCC_BBAA);
        exp_hs(5'h04, 8'h15);
        start_dut();
        put_bytes(s_nak);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        wait_idle(2000);
        check_end("nak", 1'b0, 1'b1, 2'd3);

        // Leading garbage, throttled handshake, TX full for a while
        throttle = 1'b1;
        tx_full  = 1'b1;
        exp_cfg();
        exp_mem(B, 32'h0403_0201);
        exp_hs(5'h04, 8'h06);
        start_dut();
        put_bytes(s_gar);
        i = 0;
        while (rd_ptr < 10 && i < 1000) begin
            @(posedge clk); i++;
        end
        repeat (20) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_idle(2000);
        throttle = 1'b0;
        check_end("garbage", 1'b1, 1'b0, 2'd0);

        // UART error reported in status mid-data
        force_at = 7;
        exp_cfg();
        exp_mem(B, 32'h4433_2211);
        start_dut();
        put_bytes(s_err);
        wait_idle(2000);
        check_end("uart_err", 1'b0, 1'b1, 2'd1);
        force_at = -1;

        // Length 0x1001 exceeds MAX_WORDS
        exp_cfg();
        start_dut();
        put_bytes(s_len);
        wait_idle(2000);
        check_end("length", 1'b0, 1'b1, 2'd2);

        // Memory stall for 5 cycles
        mem_ready_i = 1'b0;
        exp_cfg();
        exp_mem(B, 32'h0403_0201);
        exp_hs(5'h04, 8'h06);
        start_dut();
        put_bytes(s_gar);
        i = 0;
        while (!mem_we_o && i < 1000) begin
            @(negedge clk); i++;
        end
        n_vec++;
        if (!mem_we_o) begin
            n_err++;
            $display("FAIL stall_we got 0, required 1");
        end
        repeat (5) @(posedge clk);
        #1 mem_ready_i = 1'b1;
        wait_idle(2000);
        check_end("stall", 1'b1, 1'b0, 2'd0);

        // Reset in the middle of the data phase, then a clean reload
        exp_cfg();
        exp_mem(B, 32'h4433_2211);
        start_dut();
        put_bytes(s_ack);
        i = 0;
        while (rd_ptr < 8 && i < 1000) begin
            @(negedge clk); i++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_reset_pending got %0d outstanding events, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        exp_cfg();
        exp_mem(B, 32'h4433_2211);
        exp_mem(B + 32'd4, 32'hDDCC_BBAA);
        exp_hs(5'h04, 8'h06);
        start_dut();
        put_bytes(s_ack);
        wait_idle(2000);
        check_end("reload", 1'b1, 1'b0, 2'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
